phys_reg_freelist: RTL and testbench

R10K-style physical register free list.
- Hands up to N free physical tags per cycle to dispatch/rename.
- Reclaims tags from the retire stage (free_mask) and tracks which tags are architecturally live from the retire-stage arch-map writes.
- On a retire-time mispredict, restores the speculative free set from the architectural free set in one cycle.

---
 rtl/phys_reg_freelist_pkg.sv | 15 +
 rtl/phys_reg_freelist_picker.sv | 33 +++
 rtl/phys_reg_freelist.sv | 112 +++++++++++
 tb/tb_phys_reg_freelist.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phys_reg_freelist_pkg.sv
// Shared sizing and tag/count types for the R10K physical register free list.
// Dispatch stall logic uses FREE_CNT to compare against the number of lanes it needs.
package phys_reg_freelist_pkg;

    localparam int N_LANES          = 3;
    localparam int ARCH_REG_SZ      = 32;
    localparam int PHYS_REG_SZ_R10K = 64;

    localparam int PRW_DEF = (PHYS_REG_SZ_R10K <= 2) ? 1 : $clog2(PHYS_REG_SZ_R10K);
    localparam int CW_DEF  = $clog2(PHYS_REG_SZ_R10K + 1);

    typedef logic [PRW_DEF-1:0] PHYS_TAG;
    typedef logic [CW_DEF-1:0]  FREE_CNT;

endpackage

// File: rtl/phys_reg_freelist_picker.sv
// N-way lowest-first selector: lane i receives the (i+1)-th lowest set bit of the bitmap.
// Each lane finds the first set bit of what earlier lanes left behind, then masks it out.
module freelist_picker #(
    parameter int N   = 3,
    parameter int W   = 64,
    parameter int PRW = 6
) (
    input  logic [W-1:0]          i_bitmap,
    output logic [N-1:0][PRW-1:0] o_tags,
    output logic [N-1:0]          o_valids
);

    logic [W-1:0] w_rem;

    always_comb begin
        w_rem    = i_bitmap;
        o_tags   = '0;
        o_valids = '0;
        for (int l = 0; l < N; l++) begin
            // Descending scan, so the last hit written is the lowest set bit.
            for (int b = W - 1; b >= 0; b--) begin
                if (w_rem[b]) begin
                    o_tags[l]   = PRW'(b);
                    o_valids[l] = 1'b1;
                end
            end
            if (o_valids[l]) begin
                w_rem[o_tags[l]] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/phys_reg_freelist.sv
// R10K physical register free list: speculative and architectural free bitmaps,
// up to N allocations and N retire commits per cycle, one-cycle mispredict recovery.
module phys_reg_freelist
    import phys_reg_freelist_pkg::*;
#(
    parameter int N          = N_LANES,
    parameter int ARCH_COUNT = ARCH_REG_SZ,
    parameter int PHYS_REGS  = PHYS_REG_SZ_R10K,
    localparam int PRW       = (PHYS_REGS <= 2) ? 1 : $clog2(PHYS_REGS),
    localparam int CW        = $clog2(PHYS_REGS + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PHYS_REGS-1:0]   free_mask,
    input  logic [N-1:0]           arch_write_enables,
    input  logic [N-1:0][PRW-1:0]  arch_write_phys_regs,
    input  logic                   mispredict,
    input  logic [N-1:0]           alloc_en,
    output logic [N-1:0][PRW-1:0]  alloc_tags,
    output logic [N-1:0]           alloc_valids,
    output logic [CW-1:0]          free_count,
    output logic                   double_free_err
);

    localparam logic [PHYS_REGS-1:0] RESET_FREE =
        {{(PHYS_REGS-ARCH_COUNT){1'b1}}, {ARCH_COUNT{1'b0}}};

    logic [PHYS_REGS-1:0] r_spec_free;
    logic [PHYS_REGS-1:0] r_arch_free;
    logic [CW-1:0]        r_free_count;
    logic                 r_err;

    logic [PHYS_REGS-1:0] w_free;
    logic [PHYS_REGS-1:0] w_arch_next;
    logic [PHYS_REGS-1:0] w_alloc_mask;
    logic [PHYS_REGS-1:0] w_spec_next;
    logic [CW-1:0]        w_count_next;
    logic                 w_dbl_free;

    // The zero register is never on the free list.
    assign w_free     = {free_mask[PHYS_REGS-1:1], 1'b0};
    assign w_dbl_free = |(w_free & r_arch_free);

    always_comb begin
        w_arch_next = r_arch_free | w_free;
        for (int i = 0; i < N; i++) begin
            if (arch_write_enables[i]) begin
                w_arch_next[arch_write_phys_regs[i]] = 1'b0;
            end
        end
        w_arch_next[0] = 1'b0;
    end

    always_comb begin
        w_alloc_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (alloc_en[i] && alloc_valids[i]) begin
                w_alloc_mask[alloc_tags[i]] = 1'b1;
            end
        end
    end

    // Allocation is applied after the free so a colliding tag stays allocated.
    always_comb begin
        if (mispredict) begin
            w_spec_next = w_arch_next;
        end else begin
            w_spec_next = (r_spec_free | w_free) & ~w_alloc_mask;
        end
        w_spec_next[0] = 1'b0;
    end

    always_comb begin
        w_count_next = '0;
        for (int b = 0; b < PHYS_REGS; b++) begin
            w_count_next = w_count_next + CW'(w_spec_next[b]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_spec_free  <= RESET_FREE;
            r_arch_free  <= RESET_FREE;
            r_free_count <= CW'(PHYS_REGS - ARCH_COUNT);
            r_err        <= 1'b0;
        end else begin
            r_spec_free  <= w_spec_next;
            r_arch_free  <= w_arch_next;
            r_free_count <= w_count_next;
            r_err        <= r_err | w_dbl_free;
        end
    end

    freelist_picker #(
        .N   (N),
        .W   (PHYS_REGS),
        .PRW (PRW)
    ) u_picker (
        .i_bitmap (r_spec_free),
        .o_tags   (alloc_tags),
        .o_valids (alloc_valids)
    );

    assign free_count      = r_free_count;
    assign double_free_err = r_err;

    // Dispatch must consume a contiguous run of lanes from lane 0, all holding real tags.
    a_alloc_legal: assert property (@(posedge clock) disable iff (reset)
        (((({1'b0, alloc_en}) + 1'b1) & {1'b0, alloc_en}) == '0) &&
        ((alloc_en & ~alloc_valids) == '0));

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Randomized self-checking bench for phys_reg_freelist against a bitmap-level reference model.
module tb_phys_reg_freelist;

    localparam int N   = 3;
    localparam int P   = 64;
    localparam int A   = 32;
    localparam int PRW = 6;
    localparam int CW  = 7;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [P-1:0]          free_mask;
    logic [N-1:0]          awe;
    logic [N-1:0][PRW-1:0] awt;
    logic                  mispredict;
    logic [N-1:0]          alloc_en;
    logic [N-1:0][PRW-1:0] alloc_tags;
    logic [N-1:0]          alloc_valids;
    logic [CW-1:0]         free_count;
    logic                  double_free_err;

    phys_reg_freelist #(.N(N), .ARCH_COUNT(A), .PHYS_REGS(P)) dut (
        .clock                (clock),
        .reset                (reset),
        .free_mask            (free_mask),
        .arch_write_enables   (awe),
        .arch_write_phys_regs (awt),
        .mispredict           (mispredict),
        .alloc_en             (alloc_en),
        .alloc_tags           (alloc_tags),
        .alloc_valids         (alloc_valids),
        .free_count           (free_count),
        .double_free_err      (double_free_err)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    bit [P-1:0] m_spec;
    bit [P-1:0] m_arch;
    bit         m_err;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int t = 0; t < P; t++) begin
            m_spec[t] = (t >= A);
            m_arch[t] = (t >= A);
        end
        m_err = 1'b0;
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int t = 0; t < P; t++) c += int'(m_spec[t]);
        return c;
    endfunction

    // Free tags in ascending order; the first N of them are the candidates.
    task automatic m_cands(output logic [N-1:0][PRW-1:0] et, output logic [N-1:0] ev);
        int q[$];
        et = '0;
        ev = '0;
        for (int t = 0; t < P; t++) if (m_spec[t]) q.push_back(t);
        for (int l = 0; l < N; l++) begin
            if (l < q.size()) begin
                et[l] = PRW'(q[l]);
                ev[l] = 1'b1;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0][PRW-1:0] et;
        logic [N-1:0]          ev;
        m_cands(et, ev);
        for (int l = 0; l < N; l++) check($sformatf("alloc_tags[%0d]", l), 64'(alloc_tags[l]), 64'(et[l]));
        check("alloc_valids", 64'(alloc_valids), 64'(ev));
        check("free_count", 64'(free_count), 64'(m_cnt()));
        check("double_free_err", 64'(double_free_err), 64'(m_err));
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic m_step();
        logic [N-1:0][PRW-1:0] et;
        logic [N-1:0]          ev;
        bit [P-1:0] fm, an, sn;
        m_cands(et, ev);
        fm    = free_mask;
        fm[0] = 1'b0;
        if ((fm & m_arch) != '0) m_err = 1'b1;
        an = m_arch | fm;
        for (int l = 0; l < N; l++) if (awe[l]) an[awt[l]] = 1'b0;
        an[0] = 1'b0;
        if (mispredict) begin
            sn = an;
        end else begin
            sn = m_spec | fm;
            for (int l = 0; l < N; l++) if (alloc_en[l]) sn[et[l]] = 1'b0;
        end
        sn[0]  = 1'b0;
        m_spec = sn;
        m_arch = an;
    endtask

    task automatic idle_inputs();
        free_mask  = '0;
        awe        = '0;
        awt        = '0;
        mispredict = 1'b0;
        alloc_en   = '0;
    endtask

    task automatic step_and_compare();
        m_step();
        @(negedge clock);
        compare();
    endtask

    // Legal random traffic: each commit of an in-flight tag frees one live tag.
    task automatic random_inputs();
        int cnt, k, idx;
        int inflight[$];
        int live[$];
        idle_inputs();
        cnt = m_cnt();
        k   = $urandom_range(0, (cnt < N) ? cnt : N);
        for (int l = 0; l < k; l++) alloc_en[l] = 1'b1;
        mispredict = ($urandom_range(0, 19) == 0);
        for (int t = 1; t < P; t++) begin
            if (!m_spec[t] && m_arch[t]) inflight.push_back(t);
            if (!m_arch[t]) live.push_back(t);
        end
        for (int l = 0; l < N; l++) begin
            if ($urandom_range(0, 1) == 1 && inflight.size() > 0 && live.size() > 0) begin
                idx    = $urandom_range(0, inflight.size() - 1);
                awe[l] = 1'b1;
                awt[l] = PRW'(inflight[idx]);
                inflight.delete(idx);
                idx = $urandom_range(0, live.size() - 1);
                free_mask[live[idx]] = 1'b1;
                live.delete(idx);
            end
        end
        if ($urandom_range(0, 7) == 0) free_mask[0] = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_reset();
        #12;
        compare();
        check("reset tag0", 64'(alloc_tags[0]), 64'd32);
        check("reset tag1", 64'(alloc_tags[1]), 64'd33);
        check("reset tag2", 64'(alloc_tags[2]), 64'd34);
        check("reset valids", 64'(alloc_valids), 64'b111);
        check("reset free_count", 64'(free_count), 64'd32);
        check("reset err", 64'(double_free_err), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        compare();

        // Allocate three tags.
        alloc_en = 3'b111;
        step_and_compare();
        check("alloc tag0", 64'(alloc_tags[0]), 64'd35);
        check("alloc tag2", 64'(alloc_tags[2]), 64'd37);
        check("alloc free_count", 64'(free_count), 64'd29);

        // Retire frees tag 5 and commits tag 32.
        idle_inputs();
        free_mask[5] = 1'b1;
        awe          = 3'b001;
        awt[0]       = PRW'(32);
        step_and_compare();
        check("free tag0", 64'(alloc_tags[0]), 64'd5);
        check("free tag1", 64'(alloc_tags[1]), 64'd35);
        check("free free_count", 64'(free_count), 64'd30);

        // Mispredict: uncommitted 33,34 return; same-cycle allocation is dropped.
        idle_inputs();
        mispredict = 1'b1;
        alloc_en   = 3'b111;
        step_and_compare();
        check("mispredict tag0", 64'(alloc_tags[0]), 64'd5);
        check("mispredict tag1", 64'(alloc_tags[1]), 64'd33);
        check("mispredict tag2", 64'(alloc_tags[2]), 64'd34);
        check("mispredict free_count", 64'(free_count), 64'd32);

        // Drain to empty.
        for (int i = 0; i < 40 && m_cnt() > 0; i++) begin
            idle_inputs();
            for (int l = 0; l < N && l < m_cnt(); l++) alloc_en[l] = 1'b1;
            step_and_compare();
        end
        check("empty valids", 64'(alloc_valids), 64'd0);
        check("empty free_count", 64'(free_count), 64'd0);

        // Commit 40, then release it: offered only on the following cycle.
        idle_inputs();
        awe    = 3'b001;
        awt[0] = PRW'(40);
        step_and_compare();
        idle_inputs();
        free_mask[40] = 1'b1;
        #1;
        check("same-cycle valids", 64'(alloc_valids), 64'd0);
        step_and_compare();
        check("refill valids", 64'(alloc_valids), 64'b001);
        check("refill tag0", 64'(alloc_tags[0]), 64'd40);
        check("refill free_count", 64'(free_count), 64'd1);
        check("refill err", 64'(double_free_err), 64'd0);

        // Second release of 40 without a recommit is a double free.
        step_and_compare();
        check("double free err", 64'(double_free_err), 64'd1);
        idle_inputs();
        step_and_compare();
        check("sticky err", 64'(double_free_err), 64'd1);

        // Asynchronous reset while allocating.
        alloc_en = 3'b001;
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        compare();
        check("async reset tag0", 64'(alloc_tags[0]), 64'd32);
        check("async reset free_count", 64'(free_count), 64'd32);
        check("async reset err", 64'(double_free_err), 64'd0);
        @(negedge clock);
        idle_inputs();
        reset = 1'b0;
        compare();

        for (int c = 0; c < 3000; c++) begin
            random_inputs();
            step_and_compare();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
